// File: rtl/dcache1_tag_ctrl_if.sv
// ---------------------------------------------------------------------------
// dcache1_tag_ctrl_if
// Bundles the requester handshakes (load / fill / invalidate) and the shared
// tag-way port control bus driven by dcache1_tag_ctrl.
//   master : requester + tag-array side (drives *_req and payloads, observes
//            grants, tag_* bus and busy)
//   slave  : the tag controller itself
// ---------------------------------------------------------------------------
interface dcache1_tag_ctrl_if #(
  parameter int PADDR_WIDTH = 44
);
  localparam int LA_W = PADDR_WIDTH - 8;

  // load lookup
  logic            ld_req;
  logic [LA_W-1:0] ld_addrOdd;
  logic [LA_W-1:0] ld_addrEven;
  logic            ld_odd;
  logic            ld_split;
  logic            ld_gnt;
  // line refill
  logic            fill_req;
  logic [LA_W-1:0] fill_addr;
  logic            fill_odd;
  logic            fill_excl;
  logic            fill_gnt;
  // invalidate / snoop
  logic            inv_req;
  logic [LA_W-1:0] inv_addr;
  logic            inv_odd;
  logic            inv_gnt;
  // shared tag-way port bus
  logic            tag_read_clkEn;
  logic            tag_read_en;
  logic [LA_W-1:0] tag_read_addrOdd;
  logic [LA_W-1:0] tag_read_addrEven;
  logic            tag_read_odd;
  logic            tag_read_split;
  logic            tag_read_invl;
  logic            tag_write_wen;
  logic [5:0]      tag_write_rand;
  logic            tag_write_exclusive;
  logic            busy;

  modport master (
    output ld_req, ld_addrOdd, ld_addrEven, ld_odd, ld_split,
    output fill_req, fill_addr, fill_odd, fill_excl,
    output inv_req, inv_addr, inv_odd,
    input  ld_gnt, fill_gnt, inv_gnt,
    input  tag_read_clkEn, tag_read_en, tag_read_addrOdd, tag_read_addrEven,
    input  tag_read_odd, tag_read_split, tag_read_invl,
    input  tag_write_wen, tag_write_rand, tag_write_exclusive, busy
  );

  modport slave (
    input  ld_req, ld_addrOdd, ld_addrEven, ld_odd, ld_split,
    input  fill_req, fill_addr, fill_odd, fill_excl,
    input  inv_req, inv_addr, inv_odd,
    output ld_gnt, fill_gnt, inv_gnt,
    output tag_read_clkEn, tag_read_en, tag_read_addrOdd, tag_read_addrEven,
    output tag_read_odd, tag_read_split, tag_read_invl,
    output tag_write_wen, tag_write_rand, tag_write_exclusive, busy
  );
endinterface

// File: rtl/dcache1_tag_ctrl.sv
// ---------------------------------------------------------------------------
// dcache1_tag_ctrl
// Arbiter/sequencer for the shared read/write port of the eight dcache1 tag
// ways. Grants one of invalidate > fill > load per cycle (a starved load may
// overtake a fill), drives the tag-port control bus, produces the replacement
// way vector from a 6-bit LFSR and holds everybody off during the post-reset
// tag init sweep and for one cycle after every fill.
// Ports:
//   clk  : clock, all state changes on the falling edge (tag array timing)
//   rst  : synchronous active-high reset
//   bus  : dcache1_tag_ctrl_if.slave (requests, grants, tag bus, busy)
// Grants and tag strobes are combinational from the current requests.
// ---------------------------------------------------------------------------
module dcache1_tag_ctrl #(
  parameter int PADDR_WIDTH = 44,
`ifdef DCACHE_256K
  parameter int INIT_CYCLES = 128,
`else
  parameter int INIT_CYCLES = 64,
`endif
  parameter int STARVE_MAX  = 3
) (
  input  logic              clk,
  input  logic              rst,
  dcache1_tag_ctrl_if.slave bus
);

  localparam int LA_W  = PADDR_WIDTH - 8;
  localparam int CNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(INIT_CYCLES - 1);
  localparam logic [STV_W-1:0] STV_SAT   = STV_W'(STARVE_MAX);
  localparam logic [5:0]       LFSR_SEED = 6'b000001;

  typedef enum logic [1:0] {
    ST_INIT      = 2'd0,
    ST_IDLE      = 2'd1,
    ST_FILL_HOLD = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CNT_W-1:0] r_init_cnt;
  logic [CNT_W-1:0] w_init_cnt_nxt;
  logic [STV_W-1:0] r_starve;
  logic [STV_W-1:0] w_starve_nxt;
  logic [5:0]      r_lfsr;
  logic [5:0]      w_lfsr_nxt;

  logic [LA_W-1:0] r_addr_odd;
  logic [LA_W-1:0] r_addr_even;
  logic            r_odd;
  logic            r_split;
  logic [LA_W-1:0] w_addr_odd;
  logic [LA_W-1:0] w_addr_even;
  logic            w_odd;
  logic            w_split;

  logic            w_gnt_ld;
  logic            w_gnt_fill;
  logic            w_gnt_inv;
  logic            w_ld_boost;
  logic            w_clken;
  logic            w_ren;
  logic            w_invl;
  logic            w_wen;
  logic            w_excl;

  // x^6 + x^5 + 1: shift left, feedback of taps 6 and 5 into bit 0
  function automatic logic [5:0] lfsr_step(input logic [5:0] v);
    return {v[4:0], v[5] ^ v[4]};
  endfunction

  // a load that has lost STARVE_MAX eligible cycles in a row outranks a fill
  assign w_ld_boost = (r_starve == STV_SAT) & bus.ld_req;

  // next-state and arbitration; reset overrides everything and issues no grant
  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    w_gnt_ld       = 1'b0;
    w_gnt_fill     = 1'b0;
    w_gnt_inv      = 1'b0;
    if (rst) begin
      w_state_nxt    = ST_INIT;
      w_init_cnt_nxt = {CNT_W{1'b0}};
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_init_cnt == CNT_LAST) begin
            w_state_nxt    = ST_IDLE;
            w_init_cnt_nxt = {CNT_W{1'b0}};
          end else begin
            w_init_cnt_nxt = r_init_cnt + CNT_W'(1);
          end
        end
        ST_IDLE: begin
          if (bus.inv_req) begin
            w_gnt_inv = 1'b1;
          end else if (bus.fill_req && !w_ld_boost) begin
            w_gnt_fill  = 1'b1;
            w_state_nxt = ST_FILL_HOLD;
          end else if (bus.ld_req) begin
            w_gnt_ld = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_FILL_HOLD: begin
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt    = ST_INIT;
          w_init_cnt_nxt = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // starve counter counts only denied IDLE cycles and holds elsewhere
  always_comb begin
    if (rst) begin
      w_starve_nxt = {STV_W{1'b0}};
    end else if (!bus.ld_req || w_gnt_ld) begin
      w_starve_nxt = {STV_W{1'b0}};
    end else if ((r_state == ST_IDLE) && (r_starve != STV_SAT)) begin
      w_starve_nxt = r_starve + STV_W'(1);
    end else begin
      w_starve_nxt = r_starve;
    end
  end

  // replacement vector moves on only when a fill is actually written
  always_comb begin
    if (rst) begin
      w_lfsr_nxt = LFSR_SEED;
    end else if (w_gnt_fill) begin
      w_lfsr_nxt = lfsr_step(r_lfsr);
    end else begin
      w_lfsr_nxt = r_lfsr;
    end
  end

  // tag-port bus: granted source passes through, otherwise the last granted
  // address/odd/split are replayed from the registered copy
  always_comb begin
    w_addr_odd  = r_addr_odd;
    w_addr_even = r_addr_even;
    w_odd       = r_odd;
    w_split     = r_split;
    w_clken     = 1'b0;
    w_ren       = 1'b0;
    w_invl      = 1'b0;
    w_wen       = 1'b0;
    w_excl      = 1'b0;
    if (w_gnt_inv) begin
      w_clken     = 1'b1;
      w_ren       = 1'b1;
      w_invl      = 1'b1;
      w_addr_odd  = bus.inv_addr;
      w_addr_even = bus.inv_addr;
      w_odd       = bus.inv_odd;
      w_split     = 1'b0;
    end else if (w_gnt_fill) begin
      w_clken     = 1'b1;
      w_wen       = 1'b1;
      w_excl      = bus.fill_excl;
      w_addr_odd  = bus.fill_addr;
      w_addr_even = bus.fill_addr;
      w_odd       = bus.fill_odd;
      w_split     = 1'b0;
    end else if (w_gnt_ld) begin
      w_clken     = 1'b1;
      w_ren       = 1'b1;
      w_addr_odd  = bus.ld_addrOdd;
      w_addr_even = bus.ld_addrEven;
      w_odd       = bus.ld_odd;
      w_split     = bus.ld_split;
    end else begin
      w_clken     = 1'b0;
    end
  end

  assign bus.ld_gnt              = w_gnt_ld;
  assign bus.fill_gnt            = w_gnt_fill;
  assign bus.inv_gnt             = w_gnt_inv;
  assign bus.tag_read_clkEn      = w_clken;
  assign bus.tag_read_en         = w_ren;
  assign bus.tag_read_invl       = w_invl;
  assign bus.tag_write_wen       = w_wen;
  assign bus.tag_write_exclusive = w_excl;
  assign bus.tag_read_addrOdd    = w_addr_odd;
  assign bus.tag_read_addrEven   = w_addr_even;
  assign bus.tag_read_odd        = w_odd;
  assign bus.tag_read_split      = w_split;
  assign bus.tag_write_rand      = r_lfsr;
  assign bus.busy                = rst | (r_state != ST_IDLE);

  // state registers, falling edge to line up with the tag array
  always_ff @(negedge clk) begin
    r_state    <= w_state_nxt;
    r_init_cnt <= w_init_cnt_nxt;
    r_starve   <= w_starve_nxt;
    r_lfsr     <= w_lfsr_nxt;
    if (rst) begin
      r_addr_odd  <= {LA_W{1'b0}};
      r_addr_even <= {LA_W{1'b0}};
      r_odd       <= 1'b0;
      r_split     <= 1'b0;
    end else begin
      r_addr_odd  <= w_addr_odd;
      r_addr_even <= w_addr_even;
      r_odd       <= w_odd;
      r_split     <= w_split;
    end
  end

endmodule

// File: tb/tb_dcache1_tag_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dcache1_tag_ctrl
// Directed scenarios plus a randomized run, all checked against a cycle
// model that tracks "init cycles left / in fill hold / starve count / LFSR
// value / last granted address" and derives grants from the priority rules.
// Inputs are driven just after the falling (state) edge and outputs are
// sampled on the rising edge in between.
// ---------------------------------------------------------------------------
module tb_dcache1_tag_ctrl;

  localparam int LA_W     = 36;
  localparam int INIT_N   = 64;
  localparam int STARVE_N = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errs   = 0;

  dcache1_tag_ctrl_if #(.PADDR_WIDTH(44)) bus ();

  dcache1_tag_ctrl #(
    .PADDR_WIDTH (44),
    .INIT_CYCLES (INIT_N),
    .STARVE_MAX  (STARVE_N)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // {inv_gnt, fill_gnt, ld_gnt, clkEn, read_en, invl, wen, excl, busy}
  wire [8:0]  obs_ctl = {bus.inv_gnt, bus.fill_gnt, bus.ld_gnt, bus.tag_read_clkEn,
                         bus.tag_read_en, bus.tag_read_invl, bus.tag_write_wen,
                         bus.tag_write_exclusive, bus.busy};
  wire [73:0] obs_bus = {bus.tag_read_addrOdd, bus.tag_read_addrEven,
                         bus.tag_read_odd, bus.tag_read_split};

  // ---------------- reference model ----------------
  int         m_init_left;
  bit         m_hold;
  int         m_starve;
  int         m_lfsr;
  bit         m_addr_valid;
  logic [73:0] m_bus;

  function automatic logic [8:0] exp_ctl();
    bit idle, boost, inv, fill, ld, bsy;
    idle  = !rst && (m_init_left == 0) && !m_hold;
    boost = (m_starve == STARVE_N) && bus.ld_req;
    inv   = idle && bus.inv_req;
    fill  = idle && !bus.inv_req && bus.fill_req && !boost;
    ld    = idle && !inv && !fill && bus.ld_req;
    bsy   = rst || (m_init_left > 0) || m_hold;
    return {inv, fill, ld, inv | fill | ld, inv | ld, inv, fill, fill & bus.fill_excl, bsy};
  endfunction

  function automatic logic [73:0] exp_bus(input logic [8:0] c);
    if (c[8])      return {bus.inv_addr, bus.inv_addr, bus.inv_odd, 1'b0};
    else if (c[7]) return {bus.fill_addr, bus.fill_addr, bus.fill_odd, 1'b0};
    else if (c[6]) return {bus.ld_addrOdd, bus.ld_addrEven, bus.ld_odd, bus.ld_split};
    else           return m_bus;
  endfunction

  task automatic mdl_advance();
    logic [8:0] c;
    c = exp_ctl();
    if (rst) begin
      m_init_left  = INIT_N;
      m_hold       = 1'b0;
      m_starve     = 0;
      m_lfsr       = 1;
      m_addr_valid = 1'b0;
    end else begin
      if (c[8] | c[7] | c[6]) begin
        m_bus        = exp_bus(c);
        m_addr_valid = 1'b1;
      end
      if (!bus.ld_req || c[6]) m_starve = 0;
      else if (m_init_left == 0 && !m_hold && m_starve < STARVE_N) m_starve++;
      if (c[7]) m_lfsr = ((m_lfsr << 1) & 63) | (((m_lfsr >> 5) ^ (m_lfsr >> 4)) & 1);
      if (m_init_left > 0) m_init_left--;
      else if (m_hold)     m_hold = 1'b0;
      else if (c[7])       m_hold = 1'b1;
    end
  endtask

  // ---------------- stimulus plumbing ----------------
  task automatic at_sample();
    @(posedge clk);
  endtask

  task automatic end_cycle();
    @(negedge clk);
    mdl_advance();
    #1;
  endtask

  task automatic set_reqs(input bit inv, input bit fill, input bit ld);
    bus.inv_req  = inv;
    bus.fill_req = fill;
    bus.ld_req   = ld;
  endtask

  task automatic rand_payload();
    bus.ld_addrOdd  = {$urandom_range(0, 15), $urandom};
    bus.ld_addrEven = {$urandom_range(0, 15), $urandom};
    bus.ld_odd      = $urandom_range(0, 1);
    bus.ld_split    = $urandom_range(0, 1);
    bus.fill_addr   = {$urandom_range(0, 15), $urandom};
    bus.fill_odd    = $urandom_range(0, 1);
    bus.fill_excl   = $urandom_range(0, 1);
    bus.inv_addr    = {$urandom_range(0, 15), $urandom};
    bus.inv_odd     = $urandom_range(0, 1);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int bad;
    rst = 1'b1;
    set_reqs(1'b1, 1'b1, 1'b1);
    rand_payload();
    end_cycle();
    at_sample();
    n_checks++;
    if (obs_ctl !== 9'h001) begin
      n_errs++; $display("FAIL reset_ctl: got %h want %h", obs_ctl, 9'h001);
    end
    end_cycle();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < INIT_N; i++) begin
      at_sample();
      if (obs_ctl !== exp_ctl() || obs_ctl !== 9'h001) bad++;
      end_cycle();
    end
    n_checks++;
    if (bad !== 0) begin
      n_errs++; $display("FAIL init_sweep: %0d bad cycles, want 0", bad);
    end
    at_sample();
    n_checks++;
    if (obs_ctl !== 9'h138) begin
      n_errs++; $display("FAIL init_exit_inv: got %h want %h", obs_ctl, 9'h138);
    end
  endtask

  task automatic test_priority();
    // still in cycle INIT_N with all three requests up
    n_checks++;
    if (obs_bus !== exp_bus(exp_ctl())) begin
      n_errs++; $display("FAIL prio_inv_bus: got %h want %h", obs_bus, exp_bus(exp_ctl()));
    end
    end_cycle();
    set_reqs(1'b0, 1'b1, 1'b1);
    bus.fill_excl = 1'b0;
    at_sample();
    n_checks++;
    if (obs_ctl !== 9'h0A4) begin
      n_errs++; $display("FAIL prio_fill: got %h want %h", obs_ctl, 9'h0A4);
    end
    n_checks++;
    if (obs_bus !== exp_bus(exp_ctl())) begin
      n_errs++; $display("FAIL prio_fill_bus: got %h want %h", obs_bus, exp_bus(exp_ctl()));
    end
    end_cycle();
  endtask

  task automatic test_fill_hold();
    set_reqs(1'b0, 1'b0, 1'b0);
    at_sample();
    n_checks++;
    if (obs_ctl !== 9'h001) begin
      n_errs++; $display("FAIL hold_after_prio: got %h want %h", obs_ctl, 9'h001);
    end
    end_cycle();
    set_reqs(1'b0, 1'b1, 1'b0);
    bus.fill_addr = 36'h123;
    bus.fill_odd  = 1'b1;
    bus.fill_excl = 1'b1;
    at_sample();
    n_checks++;
    if (obs_ctl !== 9'h0A6) begin
      n_errs++; $display("FAIL fill_ctl: got %h want %h", obs_ctl, 9'h0A6);
    end
    n_checks++;
    if (obs_bus !== {36'h123, 36'h123, 1'b1, 1'b0}) begin
      n_errs++; $display("FAIL fill_bus: got %h want %h", obs_bus, {36'h123, 36'h123, 1'b1, 1'b0});
    end
    end_cycle();
    set_reqs(1'b0, 1'b0, 1'b1);
    rand_payload();
    at_sample();
    n_checks++;
    if (obs_ctl !== 9'h001) begin
      n_errs++; $display("FAIL fill_hold: got %h want %h", obs_ctl, 9'h001);
    end
    end_cycle();
    at_sample();
    n_checks++;
    if (obs_ctl !== 9'h070) begin
      n_errs++; $display("FAIL ld_after_hold: got %h want %h", obs_ctl, 9'h070);
    end
    n_checks++;
    if (obs_bus !== {bus.ld_addrOdd, bus.ld_addrEven, bus.ld_odd, bus.ld_split}) begin
      n_errs++; $display("FAIL ld_bus: got %h want %h", obs_bus,
                         {bus.ld_addrOdd, bus.ld_addrEven, bus.ld_odd, bus.ld_split});
    end
    end_cycle();
    set_reqs(1'b0, 1'b0, 1'b0);
    rand_payload();
    at_sample();
    n_checks++;
    if (obs_bus !== m_bus) begin
      n_errs++; $display("FAIL addr_hold: got %h want %h", obs_bus, m_bus);
    end
    end_cycle();
  endtask

  task automatic test_starve();
    logic [1:0] want;
    set_reqs(1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 7; c++) begin
      at_sample();
      // fill on eligible cycles 0,2,4 (odd cycles are fill holds), load on 6
      want = (c == 6) ? 2'b01 : ((c % 2 == 0) ? 2'b10 : 2'b00);
      n_checks++;
      if ({bus.fill_gnt, bus.ld_gnt} !== want || obs_ctl !== exp_ctl()) begin
        n_errs++; $display("FAIL starve_c%0d: got %b ctl %h want %b ctl %h",
                           c, {bus.fill_gnt, bus.ld_gnt}, obs_ctl, want, exp_ctl());
      end
      end_cycle();
    end
    set_reqs(1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 6; c++) begin
      at_sample();
      n_checks++;
      if ({bus.inv_gnt, bus.ld_gnt} !== 2'b10) begin
        n_errs++; $display("FAIL inv_beats_starved_ld_c%0d: got %b want 10",
                           c, {bus.inv_gnt, bus.ld_gnt});
      end
      end_cycle();
    end
    set_reqs(1'b0, 1'b1, 1'b1);
    at_sample();
    n_checks++;
    if ({bus.fill_gnt, bus.ld_gnt} !== 2'b01) begin
      n_errs++; $display("FAIL boost_after_inv: got %b want 01", {bus.fill_gnt, bus.ld_gnt});
    end
    end_cycle();
  endtask

  task automatic test_lfsr();
    logic [5:0] tbl [7];
    tbl = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h21, 6'h03};
    rst = 1'b1;
    set_reqs(1'b0, 1'b0, 1'b0);
    end_cycle();
    rst = 1'b0;
    for (int i = 0; i < INIT_N; i++) end_cycle();
    for (int k = 0; k < 6; k++) begin
      set_reqs(1'b0, 1'b1, 1'b0);
      at_sample();
      n_checks++;
      if (bus.tag_write_rand !== tbl[k] || bus.fill_gnt !== 1'b1) begin
        n_errs++; $display("FAIL lfsr_fill%0d: rand %h gnt %b want %h 1",
                           k, bus.tag_write_rand, bus.fill_gnt, tbl[k]);
      end
      end_cycle();
      set_reqs(1'b0, 1'b0, 1'b0);
      at_sample();
      n_checks++;
      if (bus.tag_write_rand !== tbl[k+1] || bus.tag_write_rand === 6'h00) begin
        n_errs++; $display("FAIL lfsr_after%0d: rand %h want %h",
                           k, bus.tag_write_rand, tbl[k+1]);
      end
      end_cycle();
    end
  endtask

  task automatic test_midreset();
    int bad;
    set_reqs(1'b0, 1'b1, 1'b0);
    at_sample();
    n_checks++;
    if (bus.fill_gnt !== 1'b1) begin
      n_errs++; $display("FAIL midrst_fill: got %b want 1", bus.fill_gnt);
    end
    end_cycle();
    rst = 1'b1;
    set_reqs(1'b1, 1'b1, 1'b1);
    at_sample();
    n_checks++;
    if (obs_ctl !== 9'h001) begin
      n_errs++; $display("FAIL midrst_ctl: got %h want %h", obs_ctl, 9'h001);
    end
    end_cycle();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < INIT_N; i++) begin
      at_sample();
      if (obs_ctl !== 9'h001) bad++;
      end_cycle();
    end
    n_checks++;
    if (bad !== 0) begin
      n_errs++; $display("FAIL midrst_sweep: %0d bad cycles, want 0", bad);
    end
    at_sample();
    n_checks++;
    if (obs_ctl !== 9'h138) begin
      n_errs++; $display("FAIL midrst_exit: got %h want %h", obs_ctl, 9'h138);
    end
    end_cycle();
  endtask

  task automatic test_random();
    logic [8:0] ec;
    for (int n = 0; n < 500; n++) begin
      rst = ($urandom_range(0, 149) == 0);
      set_reqs($urandom_range(0, 3) == 0, $urandom_range(0, 1), $urandom_range(0, 1));
      rand_payload();
      at_sample();
      ec = exp_ctl();
      n_checks++;
      if (obs_ctl !== ec) begin
        n_errs++; $display("FAIL rnd_ctl@%0d: got %h want %h", n, obs_ctl, ec);
      end
      n_checks++;
      if (bus.tag_write_rand !== 6'(m_lfsr)) begin
        n_errs++; $display("FAIL rnd_rand@%0d: got %h want %h", n, bus.tag_write_rand, 6'(m_lfsr));
      end
      if (ec[8] | ec[7] | ec[6] | m_addr_valid) begin
        n_checks++;
        if (obs_bus !== exp_bus(ec)) begin
          n_errs++; $display("FAIL rnd_bus@%0d: got %h want %h", n, obs_bus, exp_bus(ec));
        end
      end
      end_cycle();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_reqs(1'b0, 1'b0, 1'b0);
    rand_payload();
    m_init_left  = INIT_N;
    m_hold       = 1'b0;
    m_starve     = 0;
    m_lfsr       = 1;
    m_addr_valid = 1'b0;
    m_bus        = '0;
    test_reset();
    test_priority();
    test_fill_hold();
    test_starve();
    test_lfsr();
    test_midreset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
